// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback/update sequencer driving instruction_decoder and the datapath.
// Five cycles per instruction with no backpressure; start is a one-shot pulse accepted only in IDLE.
module control_sequencer #(
  parameter int PC_WIDTH  = 5,
  parameter int LAST_ADDR = 20,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          instruction,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [31:0]          rs_data,
  input  logic [31:0]          rt_data,
  output logic                 control,
  output logic [PC_WIDTH-1:0]  next_pc_address,
  output logic [4:0]           rs_addr,
  output logic [4:0]           rt_addr,
  output logic [4:0]           rd_addr,
  output logic [15:0]          imm,
  output logic [1:0]           alu_op,
  output logic                 alu_src_imm,
  output logic                 reg_write,
  output logic                 halted,
  output logic                 bad_target,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [5:0] OP_ADD  = 6'b010000;
  localparam logic [5:0] OP_SHL  = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_SUBI = 6'b111000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  localparam logic [PC_WIDTH:0] LAST = (PC_WIDTH+1)'(LAST_ADDR);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, UPDATE, HALT
  } state_t;

  state_t             state;
  logic [31:0]        ir;
  logic               writes;
  logic               jump;
  logic [PC_WIDTH:0]  tgt;
  logic [PC_WIDTH:0]  pc_inc;
  logic [5:0]         fetch_op;

  // One extra bit so pc+1 from the top address reads as out of range instead of wrapping to 0.
  assign pc_inc   = {1'b0, pc} + (PC_WIDTH+1)'(1);
  assign fetch_op = instruction[31:26];

  // Register fields come straight from IR, which only changes at the FETCH edge.
  assign rs_addr = ir[25:21];
  assign rt_addr = ir[20:16];
  assign rd_addr = alu_src_imm ? ir[20:16] : ir[15:11];
  assign imm     = ir[15:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      ir              <= '0;
      writes          <= 1'b0;
      jump            <= 1'b0;
      tgt             <= '0;
      control         <= 1'b0;
      next_pc_address <= '0;
      alu_op          <= 2'b00;
      alu_src_imm     <= 1'b0;
      reg_write       <= 1'b0;
      halted          <= 1'b0;
      bad_target      <= 1'b0;
      instr_count     <= '0;
    end else begin
      reg_write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= FETCH;
            control         <= 1'b1;
            next_pc_address <= pc;
          end
        end
        FETCH: begin
          ir          <= instruction;
          control     <= 1'b0;
          state       <= DECODE;
          writes      <= 1'b0;
          alu_src_imm <= 1'b0;
          alu_op      <= 2'b11;
          case (fetch_op)
            OP_ADD:  begin alu_op <= 2'b00; writes <= 1'b1; end
            OP_SHL:  begin alu_op <= 2'b10; writes <= 1'b1; end
            OP_ADDI: begin alu_op <= 2'b00; writes <= 1'b1; alu_src_imm <= 1'b1; end
            OP_SUBI: begin alu_op <= 2'b01; writes <= 1'b1; alu_src_imm <= 1'b1; end
            default: ;
          endcase
        end
        DECODE: state <= EXECUTE;
        EXECUTE: begin
          state     <= WRITEBACK;
          reg_write <= writes;
          jump      <= 1'b0;
          tgt       <= pc_inc;
          if (ir[31:26] == OP_J || (ir[31:26] == OP_BEQ && rs_data == rt_data)) begin
            jump <= 1'b1;
            tgt  <= {1'b0, ir[PC_WIDTH-1:0]};
          end
        end
        WRITEBACK: begin
          state <= UPDATE;
          if (tgt <= LAST) begin
            control         <= 1'b1;
            next_pc_address <= tgt[PC_WIDTH-1:0];
          end
        end
        UPDATE: begin
          if (instr_count != '1) instr_count <= instr_count + CNT_WIDTH'(1);
          if (tgt <= LAST) begin
            state <= FETCH;
          end else begin
            state      <= HALT;
            control    <= 1'b0;
            halted     <= 1'b1;
            bad_target <= jump;
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
